// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, the shared FSM state type and the divisor
// helper for the 8N1 UART front end of the AES link.
// No ports. Imported by uart_if, uart_baud_gen and uart_core.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   OVERSAMPLE = 16;
  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // Clocks per tick for a given oversample factor, rounded down and
  // never below one so very slow clocks still produce a tick every cycle.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_if.sv
// uart_if: byte-level handshake plus serial pins of the UART.
// Signals:
//   txBegin  transmit request          din      byte to send (din[0] first)
//   txBusy   frame in progress         tx       serial output, idle high
//   rx       serial input, async       rxRdy    byte held in dout
//   rxRdyClr clears rxRdy              dout     last received byte
// Modports: master = byte controller / line driver, slave = uart_core.
interface uart_if;
  import uart_pkg::*;

  logic                 txBegin;
  logic [DATA_BITS-1:0] din;
  logic                 rxRdyClr;
  logic                 rx;
  logic                 tx;
  logic                 txBusy;
  logic                 rxRdy;
  logic [DATA_BITS-1:0] dout;

  modport master (
    output txBegin, din, rxRdyClr, rx,
    input  tx, txBusy, rxRdy, dout
  );

  modport slave (
    input  txBegin, din, rxRdyClr, rx,
    output tx, txBusy, rxRdy, dout
  );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: timing strobes for the UART.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   tx_clr        holds the bit counter at zero while the transmitter idles,
//                 so the first bit period starts exactly at frame accept
//   tx_strobe     high on the last clock of each transmit bit period
//   rx_tick       free-running 16x oversample tick for the receiver
module uart_baud_gen #(
  parameter int TX_DIV = 434,
  parameter int RX_DIV = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic tx_clr,
  output logic tx_strobe,
  output logic rx_tick
);

  localparam int TX_W = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int RX_W = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam logic [TX_W-1:0] TX_LAST = TX_W'(TX_DIV - 1);
  localparam logic [RX_W-1:0] RX_LAST = RX_W'(RX_DIV - 1);

  logic [TX_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [RX_W-1:0] rx_cnt_q, rx_cnt_d;

  always_comb begin
    tx_strobe = (tx_cnt_q == TX_LAST);
    rx_tick   = (rx_cnt_q == RX_LAST);
    tx_cnt_d  = (tx_clr || tx_strobe) ? '0 : tx_cnt_q + TX_W'(1);
    rx_cnt_d  = rx_tick ? '0 : rx_cnt_q + RX_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART byte transceiver.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   bus           uart_if.slave: txBegin/din/txBusy/tx on the transmit side,
//                 rx/rxRdy/rxRdyClr/dout on the receive side
// TX and RX run independently; all outputs are registered.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input logic  clock,
  input logic  reset,
  uart_if.slave bus
);

  localparam int TX_DIV = calc_div(CLK_FREQ, BAUD, 1);
  localparam int RX_DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam int CNT_W  = $clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

  logic tx_strobe, rx_tick;

  uart_state_e          tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;

  uart_state_e          rx_state_q, rx_state_d;
  logic                 sync1_q, sync2_q;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_rdy_q, rx_rdy_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 rx_done;

  uart_baud_gen #(.TX_DIV(TX_DIV), .RX_DIV(RX_DIV)) u_baud (
    .clock     (clock),
    .reset     (reset),
    .tx_clr    (tx_state_q == IDLE),
    .tx_strobe (tx_strobe),
    .rx_tick   (rx_tick)
  );

  // Transmitter: the shift register is consumed from bit 0, and the line
  // value for the next bit is registered on the strobe that ends the current one.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      IDLE: begin
        if (bus.txBegin && !tx_busy_q) begin
          tx_shift_d = bus.din;
          tx_idx_d   = '0;
          tx_d       = START_LVL;
          tx_busy_d  = 1'b1;
          tx_state_d = START;
        end
      end
      START: begin
        if (tx_strobe) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_state_d = DATA;
        end
      end
      DATA: begin
        if (tx_strobe) begin
          if (tx_idx_q == IDX_LAST) begin
            tx_d       = STOP_LVL;
            tx_state_d = STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_idx_d   = tx_idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (tx_strobe) begin
          tx_busy_d  = 1'b0;
          tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_idx_q   <= tx_idx_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Receiver: all decisions use the synchronised line sync2_q. After a
  // framing error the FSM parks in STOP with rx_ferr set until the line idles.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = rx_ferr_q;
    dout_d     = dout_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_tick && sync2_q == START_LVL) begin
          rx_cnt_d   = '0;
          rx_state_d = START;
        end
      end
      START: begin
        if (rx_tick) begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d   = '0;
            rx_idx_d   = '0;
            rx_state_d = (sync2_q == START_LVL) ? DATA : IDLE;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (rx_tick) begin
          if (rx_cnt_q == FULL_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_idx_q == IDX_LAST) rx_state_d = STOP;
            else                      rx_idx_d   = rx_idx_q + IDX_W'(1);
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (rx_ferr_q) begin
          if (sync2_q == STOP_LVL) begin
            rx_ferr_d  = 1'b0;
            rx_state_d = IDLE;
          end
        end else if (rx_tick) begin
          if (rx_cnt_q == FULL_LAST) begin
            rx_cnt_d = '0;
            if (sync2_q == STOP_LVL) begin
              dout_d     = rx_shift_q;
              rx_done    = 1'b1;
              rx_state_d = IDLE;
            end else begin
              rx_ferr_d = 1'b1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
    // A completing byte takes priority over a simultaneous clear.
    rx_rdy_d = rx_rdy_q;
    if (bus.rxRdyClr) rx_rdy_d = 1'b0;
    if (rx_done)      rx_rdy_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
      rx_rdy_q   <= 1'b0;
      dout_q     <= '0;
    end else begin
      sync1_q    <= bus.rx;
      sync2_q    <= sync1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_rdy_q   <= rx_rdy_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.tx     = tx_q;
  assign bus.txBusy = tx_busy_q;
  assign bus.rxRdy  = rx_rdy_q;
  assign bus.dout   = dout_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: self-checking bench for uart_core at 16 clocks per bit.
// Expected bytes are queued when stimulus is driven and popped when the
// DUT produces the corresponding frame or received byte.
`timescale 1ns/1ps
module tb_uart_core;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = 16;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic rx_drv  = 1'b1;
  logic loop_en = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  uart_if bus();

  // Loopback routes the serial output straight back into the receiver.
  assign bus.rx = loop_en ? bus.tx : rx_drv;

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Starts a frame with byte b and records the line at every mid-bit,
  // plus how long txBusy stays high. Optionally fires a second request
  // with din=FF at clock ignore_at of the frame.
  task automatic capture_tx_frame(input logic [7:0] b, input int ignore_at,
                                  output logic [9:0] bits, output int busy_cnt,
                                  output int last_busy);
    bits = '0;
    busy_cnt = 0;
    last_busy = 0;
    @(negedge clock);
    bus.din = b;
    bus.txBegin = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (k == 1) bus.txBegin = 1'b0;
      if (k == ignore_at) begin
        bus.din = 8'hFF;
        bus.txBegin = 1'b1;
      end
      if (k == ignore_at + 1) bus.txBegin = 1'b0;
      if (bus.txBusy) begin
        busy_cnt++;
        last_busy = k;
      end
      if ((k % BIT) == BIT / 2 && k < 10 * BIT) bits[k / BIT] = bus.tx;
    end
  endtask

  // Drives one frame on rx and reports the frame clock where rxRdy first rose.
  task automatic send_rx_frame(input logic [7:0] b, input logic stop_lvl, output int rdy_k);
    logic [9:0] f;
    f = {stop_lvl, b, 1'b0};
    rdy_k = -1;
    for (int k = 0; k < 10 * BIT; k++) begin
      @(negedge clock);
      if (bus.rxRdy && rdy_k < 0) rdy_k = k;
      rx_drv = f[k / BIT];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus.tx !== 1'b1)     begin errors++; $display("[TB] FAIL reset_tx got %b expected 1", bus.tx); end
    checks++; if (bus.txBusy !== 1'b0) begin errors++; $display("[TB] FAIL reset_txBusy got %b expected 0", bus.txBusy); end
    checks++; if (bus.rxRdy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_rxRdy got %b expected 0", bus.rxRdy); end
    checks++; if (bus.dout !== 8'h00)  begin errors++; $display("[TB] FAIL reset_dout got %h expected 00", bus.dout); end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (bus.tx !== 1'b1)     begin errors++; $display("[TB] FAIL idle_tx got %b expected 1", bus.tx); end
  endtask

  task automatic test_tx_single();
    logic [9:0] bits, want;
    logic [7:0] exp;
    int busy_cnt, last_busy;
    tx_exp.push_back(8'hA5);
    capture_tx_frame(8'hA5, 0, bits, busy_cnt, last_busy);
    exp = tx_exp.pop_front();
    want = {1'b1, exp, 1'b0};
    checks++; if (bits !== want)    begin errors++; $display("[TB] FAIL tx_single_frame got %b expected %b", bits, want); end
    checks++; if (busy_cnt !== 160) begin errors++; $display("[TB] FAIL tx_single_busy_len got %0d expected 160", busy_cnt); end
    checks++; if (last_busy !== 160) begin errors++; $display("[TB] FAIL tx_single_busy_fall got %0d expected 160", last_busy); end
  endtask

  task automatic test_tx_ignore_busy();
    logic [9:0] bits, want;
    logic [7:0] exp;
    int busy_cnt, last_busy;
    tx_exp.push_back(8'h3C);
    capture_tx_frame(8'h3C, 50, bits, busy_cnt, last_busy);
    exp = tx_exp.pop_front();
    want = {1'b1, exp, 1'b0};
    checks++; if (bits !== want)     begin errors++; $display("[TB] FAIL tx_ignore_frame got %b expected %b", bits, want); end
    checks++; if (busy_cnt !== 160)  begin errors++; $display("[TB] FAIL tx_ignore_busy_len got %0d expected 160", busy_cnt); end
    checks++; if (last_busy !== 160) begin errors++; $display("[TB] FAIL tx_ignore_busy_fall got %0d expected 160", last_busy); end
  endtask

  task automatic test_reset_midframe();
    logic saw;
    @(negedge clock);
    bus.din = 8'h00;
    bus.txBegin = 1'b1;
    @(negedge clock);
    bus.txBegin = 1'b0;
    repeat (29) @(negedge clock);
    checks++; if (bus.txBusy !== 1'b1) begin errors++; $display("[TB] FAIL midframe_busy got %b expected 1", bus.txBusy); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.tx !== 1'b1)     begin errors++; $display("[TB] FAIL midframe_reset_tx got %b expected 1", bus.tx); end
    checks++; if (bus.txBusy !== 1'b0) begin errors++; $display("[TB] FAIL midframe_reset_busy got %b expected 0", bus.txBusy); end
    saw = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.txBusy || !bus.tx) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL midframe_resume got %b expected 0", saw); end
  endtask

  task automatic test_rx_byte();
    int rdy_k;
    logic [7:0] exp;
    rx_exp.push_back(8'h5A);
    send_rx_frame(8'h5A, 1'b1, rdy_k);
    @(negedge clock);
    rx_drv = 1'b1;
    checks++; if (rdy_k < 148 || rdy_k > 159) begin errors++; $display("[TB] FAIL rx_rdy_time got %0d expected 148..159", rdy_k); end
    checks++; if (bus.rxRdy !== 1'b1) begin errors++; $display("[TB] FAIL rx_rdy got %b expected 1", bus.rxRdy); end
    exp = rx_exp.pop_front();
    checks++; if (bus.dout !== exp) begin errors++; $display("[TB] FAIL rx_dout got %h expected %h", bus.dout, exp); end
    bus.rxRdyClr = 1'b1;
    @(negedge clock);
    bus.rxRdyClr = 1'b0;
    checks++; if (bus.rxRdy !== 1'b0) begin errors++; $display("[TB] FAIL rx_clear got %b expected 0", bus.rxRdy); end
    checks++; if (bus.dout !== exp)   begin errors++; $display("[TB] FAIL rx_dout_hold got %h expected %h", bus.dout, exp); end
  endtask

  task automatic test_rx_errors();
    logic saw;
    int rdy_k;
    logic [7:0] exp;
    // Short glitch on an idle line.
    @(negedge clock);
    rx_drv = 1'b0;
    repeat (4) @(negedge clock);
    rx_drv = 1'b1;
    saw = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (bus.rxRdy) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("[TB] FAIL rx_glitch_rdy got %b expected 0", saw); end
    // Frame with a low stop bit, line held low a while afterwards.
    send_rx_frame(8'h81, 1'b0, rdy_k);
    saw = (rdy_k >= 0);
    repeat (40) begin
      @(negedge clock);
      if (bus.rxRdy) saw = 1'b1;
    end
    rx_drv = 1'b1;
    repeat (60) begin
      @(negedge clock);
      if (bus.rxRdy) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0)      begin errors++; $display("[TB] FAIL rx_framing_rdy got %b expected 0", saw); end
    checks++; if (bus.dout !== 8'h5A) begin errors++; $display("[TB] FAIL rx_framing_dout got %h expected 5a", bus.dout); end
    // The receiver must accept a clean frame after the error.
    rx_exp.push_back(8'hC3);
    send_rx_frame(8'hC3, 1'b1, rdy_k);
    @(negedge clock);
    rx_drv = 1'b1;
    exp = rx_exp.pop_front();
    checks++; if (bus.rxRdy !== 1'b1) begin errors++; $display("[TB] FAIL rx_recover_rdy got %b expected 1", bus.rxRdy); end
    checks++; if (bus.dout !== exp)   begin errors++; $display("[TB] FAIL rx_recover_dout got %h expected %h", bus.dout, exp); end
    bus.rxRdyClr = 1'b1;
    @(negedge clock);
    bus.rxRdyClr = 1'b0;
  endtask

  task automatic test_back_to_back_loopback();
    int rdy_events;
    logic saw;
    rdy_events = 0;
    loop_en = 1'b1;
    @(negedge clock);
    for (int b = 0; b < 16; b++) rx_exp.push_back(8'(b));
    fork
      begin
        for (int b = 0; b < 16; b++) begin
          int w;
          bus.din = 8'(b);
          bus.txBegin = 1'b1;
          w = 0;
          while (!bus.txBusy && w < 400) begin @(negedge clock); w++; end
          if (b == 15) bus.txBegin = 1'b0;
          while (bus.txBusy && w < 400) begin @(negedge clock); w++; end
          checks++;
          if (w >= 400) begin errors++; $display("[TB] FAIL loop_tx_timeout got %0d clocks expected <400 (byte %0d)", w, b); end
        end
        bus.txBegin = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          int w;
          logic [7:0] exp;
          w = 0;
          while (!bus.rxRdy && w < 400) begin @(negedge clock); w++; end
          checks++;
          if (!bus.rxRdy) begin
            errors++;
            $display("[TB] FAIL loop_rx_timeout got %0d clocks expected <400 (byte %0d)", w, i);
          end else begin
            rdy_events++;
            exp = rx_exp.pop_front();
            checks++;
            if (bus.dout !== exp) begin errors++; $display("[TB] FAIL loop_rx_dout got %h expected %h", bus.dout, exp); end
            bus.rxRdyClr = 1'b1;
            @(negedge clock);
            bus.rxRdyClr = 1'b0;
            checks++;
            if (bus.rxRdy !== 1'b0) begin errors++; $display("[TB] FAIL loop_rx_clear got %b expected 0", bus.rxRdy); end
          end
        end
      end
    join
    saw = 1'b0;
    repeat (200) begin
      @(negedge clock);
      if (bus.rxRdy) saw = 1'b1;
    end
    loop_en = 1'b0;
    checks++; if (rdy_events !== 16) begin errors++; $display("[TB] FAIL loop_rdy_events got %0d expected 16", rdy_events); end
    checks++; if (saw !== 1'b0)      begin errors++; $display("[TB] FAIL loop_extra_rdy got %b expected 0", saw); end
    checks++; if (rx_exp.size() !== 0) begin errors++; $display("[TB] FAIL loop_queue_left got %0d expected 0", rx_exp.size()); end
  endtask

  initial begin
    bus.txBegin  = 1'b0;
    bus.din      = 8'h00;
    bus.rxRdyClr = 1'b0;
    $display("[TB] uart_core bench start");
    test_reset();
    test_tx_single();
    test_tx_ignore_busy();
    test_reset_midframe();
    test_rx_byte();
    test_rx_errors();
    test_back_to_back_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
